// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the memory-access pipeline stage.
package mem_stage_pkg;

   localparam int unsigned XLEN  = 32;
   localparam int unsigned CNT_W = 8;
   localparam int unsigned BE_W  = 4;
   localparam int unsigned RW_W  = 5;

   typedef enum logic {
      IDLE = 1'b0,
      WAIT = 1'b1
   } state_e;

   localparam logic [XLEN-1:0] LINK_OFFSET = 32'd4;

   localparam logic [BE_W-1:0] BE_NONE  = 4'h0;
   localparam logic [BE_W-1:0] BE_BYTE0 = 4'h1;
   localparam logic [BE_W-1:0] BE_WORD  = 4'hF;

   // One-hot byte lane for a sub-word store at the given address offset.
   function automatic logic [BE_W-1:0] byte_be(input logic [1:0] ofs);
      return BE_BYTE0 << ofs;
   endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory request/acknowledge bus between the MEM stage and the data memory.
interface mem_stage_if;
   import mem_stage_pkg::*;

   logic [XLEN-1:0] Daddr;
   logic [XLEN-1:0] Dwdata;
   logic [BE_W-1:0] Dbe;
   logic            Dreq;
   logic            Dwe;
   logic [XLEN-1:0] Drdata;
   logic            Dack;

   modport master (
      output Daddr, Dwdata, Dbe, Dreq, Dwe,
      input  Drdata, Dack
   );

   modport slave (
      input  Daddr, Dwdata, Dbe, Dreq, Dwe,
      output Drdata, Dack
   );

endinterface

// File: rtl/mem_stage_load_align.sv
// Load-data alignment: picks the addressed byte and sign-extends it for LB.
module mem_stage_load_align
   import mem_stage_pkg::*;
(
   input  logic [XLEN-1:0] rdata,
   input  logic [1:0]      ofs,
   input  logic            lb,
   output logic [XLEN-1:0] data_c
);

   logic [7:0] sel_byte;

   always_comb begin
      sel_byte = rdata[7:0];
      case (ofs)
         2'd0:    sel_byte = rdata[7:0];
         2'd1:    sel_byte = rdata[15:8];
         2'd2:    sel_byte = rdata[23:16];
         default: sel_byte = rdata[31:24];
      endcase
      data_c = lb ? {{(XLEN-8){sel_byte[7]}}, sel_byte} : rdata;
   end

endmodule

// File: rtl/mem_stage.sv
// MEM stage: data-memory handshake with timeout, branch/jump redirect,
// HI/LO writes and the MEM/WB pipeline register.
module mem_stage
   import mem_stage_pkg::*;
#(
   parameter int unsigned TIMEOUT = 16
)(
   input  logic             Clk,
   input  logic             Rst_n,
   input  logic             Branch_beq,
   input  logic             Branch_bne,
   input  logic             Bgez,
   input  logic             Bgtz,
   input  logic             Blez,
   input  logic             Bltz,
   input  logic             Jump,
   input  logic             Jal,
   input  logic             Jalr,
   input  logic             MemRead,
   input  logic             MemWr,
   input  logic             MemtoReg,
   input  logic             RegWr,
   input  logic             B,
   input  logic             LB,
   input  logic             Zero,
   input  logic             Of,
   input  logic             ZBgez,
   input  logic             ZBgtz,
   input  logic             MTHI,
   input  logic             MTLO,
   input  logic [XLEN-1:0]  PC,
   input  logic [XLEN-1:0]  BPC,
   input  logic [XLEN-1:0]  Result,
   input  logic [XLEN-1:0]  BusA,
   input  logic [XLEN-1:0]  BusB,
   input  logic [XLEN-1:0]  HiRe,
   input  logic [XLEN-1:0]  LoRe,
   input  logic [25:0]      Target,
   input  logic [RW_W-1:0]  Rw,
   mem_stage_if.master      dmem,
   output logic             Stall,
   output logic             Flush,
   output logic [XLEN-1:0]  NextPC,
   output logic             RegWr_wb,
   output logic [RW_W-1:0]  Rw_wb,
   output logic [XLEN-1:0]  WbData_wb,
   output logic [XLEN-1:0]  Hi,
   output logic [XLEN-1:0]  Lo,
   output logic             MemErr
);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             access;
   logic             dreq;
   logic             completing;
   logic             timed_out;
   logic             br_taken;
   logic [XLEN-1:0]  aligned;
   logic [XLEN-1:0]  ld_data;
   logic [XLEN-1:0]  wb_data;

   assign access = MemRead | MemWr;

   // State and wait-counter register.
   always_ff @(posedge Clk) begin
      if (!Rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Handshake sequencing; a timeout completes the access with zeroed read data.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      dreq       = 1'b0;
      completing = 1'b0;
      timed_out  = 1'b0;
      case (state_q)
         IDLE: begin
            if (access) begin
               dreq = 1'b1;
               if (dmem.Dack) begin
                  completing = 1'b1;
               end else begin
                  state_d = WAIT;
                  cnt_d   = '0;
               end
            end
         end
         WAIT: begin
            dreq  = 1'b1;
            cnt_d = cnt_q + CNT_W'(1);
            if (dmem.Dack) begin
               completing = 1'b1;
               state_d    = IDLE;
            end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
               completing = 1'b1;
               timed_out  = 1'b1;
               state_d    = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign Stall       = access & ~completing;
   assign dmem.Dreq   = dreq;
   assign dmem.Dwe    = dreq & MemWr;
   assign dmem.Daddr  = {Result[XLEN-1:2], 2'b00};
   assign dmem.Dwdata = B ? {4{BusB[7:0]}} : BusB;
   assign dmem.Dbe    = !access        ? BE_NONE :
                        (MemWr & B)    ? byte_be(Result[1:0]) : BE_WORD;

   mem_stage_load_align u_load_align (
      .rdata  (dmem.Drdata),
      .ofs    (Result[1:0]),
      .lb     (LB),
      .data_c (aligned)
   );

   assign ld_data = timed_out ? '0 : aligned;

   always_comb begin
      wb_data = Result;
      if (Jal | Jalr)    wb_data = PC + LINK_OFFSET;
      else if (MemtoReg) wb_data = ld_data;
   end

   assign br_taken = (Branch_beq & Zero)  | (Branch_bne & ~Zero)  |
                     (Bgez & ZBgez)       | (Bgtz & ZBgtz)        |
                     (Blez & ~ZBgtz)      | (Bltz & ~ZBgez);

   // Redirect priority: register jump, then absolute jump, then branch.
   always_comb begin
      Flush  = 1'b0;
      NextPC = '0;
      if (Jalr) begin
         Flush  = 1'b1;
         NextPC = BusA;
      end else if (Jump | Jal) begin
         Flush  = 1'b1;
         NextPC = {PC[31:28], Target, 2'b00};
      end else if (br_taken) begin
         Flush  = 1'b1;
         NextPC = BPC;
      end
   end

   // MEM/WB register, HI/LO and sticky error flag; stalled cycles write a bubble.
   always_ff @(posedge Clk) begin
      if (!Rst_n) begin
         RegWr_wb  <= 1'b0;
         Rw_wb     <= '0;
         WbData_wb <= '0;
         Hi        <= '0;
         Lo        <= '0;
         MemErr    <= 1'b0;
      end else begin
         if (Stall) begin
            RegWr_wb  <= 1'b0;
            Rw_wb     <= '0;
            WbData_wb <= '0;
         end else begin
            RegWr_wb  <= RegWr & ~Of;
            Rw_wb     <= Rw;
            WbData_wb <= wb_data;
         end
         if (!Stall && MTHI) Hi <= HiRe;
         if (!Stall && MTLO) Lo <= LoRe;
         if (timed_out)      MemErr <= 1'b1;
      end
   end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the five-stage pipeline. It sits between the EX/MEM pipeline register and the register-file write port. It does the following:
- drives the data-memory request/acknowledge handshake and stalls the front of the pipe while an access is outstanding;
- resolves branches and jumps and writes the HI/LO registers;
- owns the MEM/WB pipeline register that feeds write-back.

## Interface
- TIMEOUT, 16: maximum cycles spent waiting for Dack before an access is abandoned; valid range 1–255.
- Clk  in  1  rising-edge clock.
- Rst_n  in  1  reset: one clock, synchronous, active-low.
- Branch_beq, Branch_bne, Bgez, Bgtz, Blez, Bltz, Jump, Jal, Jalr  in  1 each  branch/jump class from EX/MEM.
- MemRead, MemWr, MemtoReg, RegWr, B, LB, Zero, Of, ZBgez, ZBgtz, MTHI, MTLO  in  1 each  control and flags from EX/MEM.
- PC, BPC, Result, BusA, BusB, HiRe, LoRe  in  32 each  EX/MEM datapath.
- Target  in  26  jump field.
- Rw  in  5  destination register.
- Daddr  out  32  word address, {Result[31:2],2'b00}.
- Dwdata  out  32  store data.
- Dbe  out  4  byte enables.
- Dreq, Dwe  out  1 each  request and write strobe.
- Drdata  in  32  read data.
- Dack  in  1  access complete.
- Stall  out  1  freeze PC, IF/ID, ID/EX and EX/MEM.
- Flush  out  1  squash IF/ID and ID/EX.
- NextPC  out  32  redirect target, valid when Flush=1.
- RegWr_wb  out  1  MEM/WB write enable.
- Rw_wb  out  5  MEM/WB destination register.
- WbData_wb  out  32  MEM/WB write data.
- Hi, Lo  out  32 each  architectural HI/LO.
- MemErr  out  1  sticky timeout flag.

## Operation
- Access present when MemRead|MemWr. Stores: word gives Dbe=4'hF and Dwdata=BusB. B=1 gives Dbe=1<<Result[1:0] and Dwdata={4{BusB[7:0]}}.
- FSM states IDLE, WAIT.
  - IDLE with access: Dreq=1. If Dack=1 the access completes this cycle; otherwise go to WAIT and clear the wait counter.
  - WAIT: Dreq, Daddr, Dwdata, Dbe and Dwe are held. The counter increments each cycle.
  - Dack=1 completes the access and returns to IDLE.
  - Counter reaching TIMEOUT-1 with no Dack also completes the access, with read data forced to 0. It sets MemErr and returns to IDLE.
- Stall = access & !completing, in both IDLE and WAIT.
- Load data:
  - LB selects byte Result[1:0] of Drdata and sign-extends it.
  - Otherwise the full Drdata word is used.
- Write-back select, in priority order: Jal|Jalr gives PC+4; MemtoReg gives load data; otherwise Result.
- RegWr_wb = RegWr & !Of & !Stall. A stalled cycle writes a bubble: RegWr_wb=0, Rw_wb=0, WbData_wb=0.
- Branch taken conditions:
  - beq&Zero, bne&!Zero
  - Bgez&ZBgez, Bgtz&ZBgtz
  - Blez&!ZBgtz, Bltz&!ZBgez
- Redirect, with Flush=1 and priority Jalr > Jump|Jal > branch:
  - Jalr: NextPC = BusA.
  - Jump|Jal: NextPC = {PC[31:28],Target,2'b00}.
  - taken branch: NextPC = BPC.
- No branch/jump and an access are present together.
- HI/LO: MTHI loads Hi←HiRe; MTLO loads Lo←LoRe. Both may fire in the same cycle. Neither updates while Stall=1.

## Timing
- Reset values: all registered outputs are 0, the FSM is in IDLE and the counter is 0.
  - Covers Hi, Lo, RegWr_wb, Rw_wb, WbData_wb and MemErr.
  - MemErr clears only on reset.
  - Reset taken while in WAIT drops the request: Dreq=0 in the next cycle.
- Stall, Flush, NextPC, Dreq, Dbe, Dwe and Daddr are combinational from inputs and state.
- MEM/WB outputs update on the Clk edge that ends the completing cycle.
- A zero-wait access costs 0 stall cycles; Dack arriving k cycles after the request costs k stall cycles.
- Flush is asserted in the single cycle the instruction occupies MEM.
- A timeout access costs exactly TIMEOUT stall cycles.

## Structure
- Shared package holds:
  - FSM state encoding: IDLE=1'b0, WAIT=1'b1;
  - link offset constant 4;
  - byte-enable constants.
- One natural sub-module: load_align, a combinational byte select plus sign-extension. Everything else lives in mem_stage.

## Test plan
- Zero-wait load word: Dack tied high, MemRead, MemtoReg, RegWr, Rw=5, Drdata=32'h1234_5678 → Stall never asserted; next edge gives RegWr_wb=1, Rw_wb=5, WbData_wb=32'h1234_5678.
- LB with 3-cycle Dack: Result=32'h103, Drdata=32'h80FF_FFFF → Stall high for 3 cycles with bubbles written; then WbData_wb=32'hFFFF_FF80.
- SB: Result=32'h202, BusB=32'hAB → Dbe=4'b0100, Dwdata=32'hABAB_ABAB, Dwe=1, RegWr_wb=0.
- Timeout with TIMEOUT=4 and Dack held low: load completes after 4 stall cycles; WbData_wb=0; MemErr=1 until Rst_n=0.
- Branches:
  - Bltz with ZBgez=0, BPC=32'h40 → Flush=1, NextPC=32'h40.
  - Jalr with BusA=32'h80, PC=32'h10 → NextPC=32'h80, WbData_wb=32'h14.
- MTHI and MTLO in the same cycle with HiRe=7, LoRe=9 → Hi=7, Lo=9; a reset asserted mid-WAIT returns both to 0 and drops Dreq.
